// File: rtl/bcd_7seg_scan.sv
// Two-digit multiplexed seven-segment driver: a shadow register captures {TENS,ONES},
// and the shown value updates only at frame boundaries. Optional macro: SEG_LZB_EN (leading-zero blanking).
module bcd_7seg_scan #(
    parameter int unsigned REFRESH_DIV = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       LOAD,
    input  logic [3:0] TENS,
    input  logic [3:0] ONES,
    output logic [6:0] SEG,
    output logic [1:0] AN,
    output logic       FRAME
);

    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        S_ONES = 2'd0,
        S_GAP0 = 2'd1,
        S_TENS = 2'd2,
        S_GAP1 = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    shadow_q, shadow_d;
    logic [7:0]    disp_q, disp_d;

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'h3F;
            4'd1:    enc = 7'h06;
            4'd2:    enc = 7'h5B;
            4'd3:    enc = 7'h4F;
            4'd4:    enc = 7'h66;
            4'd5:    enc = 7'h6D;
            4'd6:    enc = 7'h7D;
            4'd7:    enc = 7'h07;
            4'd8:    enc = 7'h7F;
            4'd9:    enc = 7'h6F;
            default: enc = 7'h40;
        endcase
    endfunction

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_ONES;
            cnt_q    <= '0;
            shadow_q <= '0;
            disp_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = LOAD ? {TENS, ONES} : shadow_q;
        // disp sees the pre-edge shadow, so a LOAD on the boundary edge waits a frame
        disp_d   = (state_q == S_GAP1) ? shadow_q : disp_q;
        case (state_q)
            S_ONES: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_GAP0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP0: state_d = S_TENS;
            S_TENS: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_GAP1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP1: state_d = S_ONES;
            default: begin
                state_d = S_ONES;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        AN    = 2'b00;
        SEG   = 7'h00;
        FRAME = 1'b0;
        case (state_q)
            S_ONES: begin
                AN  = 2'b01;
                SEG = enc(disp_q[3:0]);
            end
            S_TENS: begin
`ifdef SEG_LZB_EN
                if (disp_q[7:4] != 4'd0) begin
                    AN  = 2'b10;
                    SEG = enc(disp_q[7:4]);
                end
`else
                AN  = 2'b10;
                SEG = enc(disp_q[7:4]);
`endif
            end
            S_GAP1:  FRAME = 1'b1;
            default: ;
        endcase
    end

endmodule
